// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bundle between pipeline datapath and controller
interface pipe_hazard_ctrl_if;
    logic [3:0]  id_rn;
    logic        id_rn_used;
    logic [3:0]  id_rm;
    logic        id_rm_used;
    logic [3:0]  id_rd;
    logic        id_rwrite;
    logic        id_load;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        stall_mem;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        mem_err;
    logic [31:0] stall_count;

    modport master (
        output id_rn, id_rn_used, id_rm, id_rm_used, id_rd, id_rwrite, id_load,
        output ex_branch_taken, mem_req, mem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        input  fwd_a, fwd_b, mem_err, stall_count
    );

    modport slave (
        input  id_rn, id_rn_used, id_rm, id_rm_used, id_rd, id_rwrite, id_load,
        input  ex_branch_taken, mem_req, mem_ready,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
        output fwd_a, fwd_b, mem_err, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline stall/flush/forward sequencing controller
// Tracks shadow copies of E/M/W destination info so datapath registers are never read back.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic {RUN, MEMWAIT} state_t;

    typedef struct packed {
        logic [3:0] rd;
        logic       rwrite;
        logic       load;
    } dst_t;

    typedef struct packed {
        logic [3:0] rn;
        logic       rn_used;
        logic [3:0] rm;
        logic       rm_used;
        dst_t       dst;
    } ex_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wcnt_q, wcnt_d;
    ex_t         e_q, e_d;
    dst_t        m_q, m_d;
    dst_t        w_q, w_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic mem_hold, mem_abort, load_use;
    logic act_hold, act_branch, act_lu, stall_front;

    // r15 is the PC, so a write to it never feeds a dependent operand.
    function automatic logic reg_match(input logic [3:0] rd, input logic [3:0] src);
        return (rd != 4'd15) && (rd == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used,
                                           input dst_t m, input dst_t w);
        if (!used)
            return 2'b00;
        if (m.rwrite && !m.load && reg_match(m.rd, src))
            return 2'b10;
        if (w.rwrite && reg_match(w.rd, src))
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        mem_hold   = 1'b0;
        mem_abort  = 1'b0;
        if (state_q == RUN) begin
            mem_hold = bus.mem_req && !bus.mem_ready;
        end else begin
            mem_hold  = !bus.mem_ready && (wcnt_q != TIMEOUT);
            mem_abort = !bus.mem_ready && (wcnt_q == TIMEOUT);
        end

        load_use = e_q.dst.load && e_q.dst.rwrite &&
                   ((bus.id_rn_used && reg_match(e_q.dst.rd, bus.id_rn)) ||
                    (bus.id_rm_used && reg_match(e_q.dst.rd, bus.id_rm)));

        // Gating with reset keeps every control output quiet while reset is held.
        act_hold    = !reset && mem_hold;
        act_branch  = !reset && !mem_hold && bus.ex_branch_taken;
        act_lu      = !reset && !mem_hold && !bus.ex_branch_taken && load_use;
        stall_front = act_hold || act_lu;
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        e_d           = e_q;
        m_d           = m_q;
        w_d           = w_q;
        mem_err_d     = mem_abort;
        stall_count_d = stall_count_q;

        if (stall_front && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;

        if (mem_hold) begin
            w_d = '0;
            if (state_q == RUN) begin
                state_d = MEMWAIT;
                wcnt_d  = 8'd1;
            end else begin
                wcnt_d  = wcnt_q + 8'd1;
            end
        end else begin
            state_d = RUN;
            wcnt_d  = 8'd0;
            w_d     = m_q;
            // An aborted access retires without writing anything back.
            if (mem_abort) begin
                w_d.rwrite = 1'b0;
                w_d.load   = 1'b0;
            end
            m_d = e_q.dst;
            if (act_branch || act_lu) begin
                e_d = '0;
            end else begin
                e_d.rn         = bus.id_rn;
                e_d.rn_used    = bus.id_rn_used;
                e_d.rm         = bus.id_rm;
                e_d.rm_used    = bus.id_rm_used;
                e_d.dst.rd     = bus.id_rd;
                e_d.dst.rwrite = bus.id_rwrite;
                e_d.dst.load   = bus.id_load;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wcnt_q        <= 8'd0;
            e_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            mem_err_q     <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            e_q           <= e_d;
            m_q           <= m_d;
            w_q           <= w_d;
            mem_err_q     <= mem_err_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_if    = stall_front;
    assign bus.stall_id    = stall_front;
    assign bus.stall_ex    = act_hold;
    assign bus.stall_mem   = act_hold;
    assign bus.flush_id    = act_branch;
    assign bus.flush_ex    = act_branch || act_lu;
    assign bus.fwd_a       = fwd_sel(e_q.rn, e_q.rn_used, m_q, w_q);
    assign bus.fwd_b       = fwd_sel(e_q.rm, e_q.rm_used, m_q, w_q);
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed and random traffic
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit rst; int rn; bit rnu; int rm; bit rmu; int rd; bit wr; bit ld;
        bit br; bit req; bit rdy;
    } stim_t;

    typedef struct {
        int rd; bit wr; bit ld; int rn; bit rnu; int rm; bit rmu;
    } ins_t;

    typedef struct {
        logic [9:0]  ctrl;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t  sb[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: instructions in flight, wait bookkeeping, stall tally.
    ins_t   me, mm, mw;
    bit     m_wait;
    int     m_wcnt;
    bit     m_err;
    longint m_cnt;

    function automatic ins_t bubble();
        ins_t b = '{default: 0};
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        return s;
    endfunction

    function automatic bit hit(int rd, int src);
        return rd != 15 && rd == src;
    endfunction

    function automatic logic [1:0] mfwd(int src, bit used);
        if (!used) return 2'b00;
        if (mm.wr && !mm.ld && hit(mm.rd, src)) return 2'b10;
        if (mw.wr && hit(mw.rd, src)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        me = bubble(); mm = bubble(); mw = bubble();
        m_wait = 0; m_wcnt = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit hold, abort, br, lu, sif;
        @(negedge clk);
        reset                  = s.rst;
        bus.id_rn              = 4'(s.rn);
        bus.id_rn_used         = s.rnu;
        bus.id_rm              = 4'(s.rm);
        bus.id_rm_used         = s.rmu;
        bus.id_rd              = 4'(s.rd);
        bus.id_rwrite          = s.wr;
        bus.id_load            = s.ld;
        bus.ex_branch_taken    = s.br;
        bus.mem_req            = s.req;
        bus.mem_ready          = s.rdy;
        if (s.rst) begin
            model_reset();
            e.ctrl = '0; e.err = 1'b0; e.cnt = '0;
            sb.push_back(e);
            @(posedge clk);
            return;
        end
        hold  = m_wait ? (!s.rdy && m_wcnt != TO) : (s.req && !s.rdy);
        abort = m_wait && !s.rdy && m_wcnt == TO;
        br    = !hold && s.br;
        lu    = !hold && !s.br && me.ld && me.wr &&
                ((s.rnu && hit(me.rd, s.rn)) || (s.rmu && hit(me.rd, s.rm)));
        sif   = hold || lu;
        e.ctrl = {sif, sif, hold, hold, br, br || lu, mfwd(me.rn, me.rnu), mfwd(me.rm, me.rmu)};
        e.err  = m_err;
        e.cnt  = m_cnt[31:0];
        sb.push_back(e);
        @(posedge clk);
        m_err = abort;
        if (sif && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
        if (hold) begin
            mw = bubble();
            if (!m_wait) begin m_wait = 1; m_wcnt = 1; end
            else m_wcnt++;
        end else begin
            mw = mm;
            if (abort) begin mw.wr = 0; mw.ld = 0; end
            mm = me;
            if (br || lu) me = bubble();
            else me = '{rd: s.rd, wr: s.wr, ld: s.ld, rn: s.rn, rnu: s.rnu, rm: s.rm, rmu: s.rmu};
            m_wait = 0; m_wcnt = 0;
        end
    endtask

    initial begin
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                       bus.flush_id, bus.flush_ex, bus.fwd_a, bus.fwd_b};
                check("ctrl", 32'(act), 32'(e.ctrl));
                check("mem_err", 32'(bus.mem_err), 32'(e.err));
                check("stall_count", bus.stall_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int rreg();
        int r = int'($urandom_range(0, 4));
        return (r == 4) ? 15 : r;
    endfunction

    initial begin
        stim_t s;
        reset = 1'b1;
        model_reset();

        s = idle(); s.rst = 1; repeat (2) step(s);

        // Load-use: LDR r3 then ADD r4, r3
        s = idle(); s.rd = 3; s.wr = 1; s.ld = 1; step(s);
        s = idle(); s.rd = 4; s.wr = 1; s.rn = 3; s.rnu = 1; step(s); step(s);
        s = idle(); repeat (2) step(s);

        // ALU chain on r2, then a write to r15
        s = idle(); s.rd = 2; s.wr = 1; step(s);
        s.rn = 2; s.rnu = 1; s.rd = 5; step(s);
        s.rd = 6; step(s);
        s = idle(); s.rd = 15; s.wr = 1; step(s);
        s.rn = 15; s.rnu = 1; s.rm = 15; s.rmu = 1; s.rd = 7; step(s);
        s = idle(); repeat (2) step(s);

        // Branch taken with a load-use hazard pending
        s = idle(); s.rd = 5; s.wr = 1; s.ld = 1; step(s);
        s = idle(); s.rn = 5; s.rnu = 1; s.br = 1; step(s);
        s = idle(); step(s);

        // Three-cycle memory wait with a branch frozen in E
        s = idle(); s.req = 1; s.br = 1; repeat (3) step(s);
        s.rdy = 1; step(s);
        s = idle(); step(s);

        // Timeout on a load whose consumer then sees no forward
        s = idle(); s.rd = 8; s.wr = 1; s.ld = 1; step(s);
        s = idle(); step(s);
        s.rn = 8; s.rnu = 1; s.rd = 9; s.wr = 1; s.req = 1; repeat (5) step(s);
        s = idle(); repeat (2) step(s);

        // Reset in the middle of a wait
        s = idle(); s.req = 1; repeat (2) step(s);
        s.rst = 1; step(s);
        s = idle(); s.rd = 1; s.wr = 1; step(s);
        s = idle(); s.rn = 1; s.rnu = 1; repeat (2) step(s);

        repeat (3000) begin
            s      = idle();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.rn   = rreg(); s.rnu = $urandom_range(0, 1) != 0;
            s.rm   = rreg(); s.rmu = $urandom_range(0, 1) != 0;
            s.rd   = rreg(); s.wr  = $urandom_range(0, 3) != 0;
            s.ld   = $urandom_range(0, 2) == 0;
            s.br   = $urandom_range(0, 7) == 0;
            s.req  = $urandom_range(0, 3) == 0;
            s.rdy  = $urandom_range(0, 3) == 0;
            step(s);
        end

        s = idle(); step(s);
        @(negedge clk);
        #5;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core (IF, ID, EX, MEM, WB). It drives the stall and flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage operand forwarding selects. It handles three cases: load-use stalls, taken-branch flushes, and data-memory wait states with a timeout. It keeps its own shadow copy of each in-flight instruction's destination register, write enable and load flag, so the datapath registers never need to be read back.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive MEMWAIT cycles before abort (range 1..255).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `id_rn` in 4: ID-stage first source register.
- `id_rn_used` in 1: `id_rn` is read by the ID instruction.
- `id_rm` in 4: ID-stage second source register.
- `id_rm_used` in 1: `id_rm` is read by the ID instruction.
- `id_rd` in 4: ID-stage destination register.
- `id_rwrite` in 1: ID instruction writes `id_rd`.
- `id_load` in 1: ID instruction is a load.
- `ex_branch_taken` in 1: the EX-stage branch resolved taken this cycle.
- `mem_req` in 1: the MEM-stage instruction accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem` out 1 each: hold the PC, IF/ID, ID/EX and EX/MEM registers respectively.
- `flush_id`, `flush_ex` out 1 each: load a bubble into IF/ID and ID/EX respectively.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 00 = register file, 10 = MEM-stage ALU result, 01 = WB result.
- `mem_err` out 1: one-cycle pulse when a memory access is aborted by timeout.
- `stall_count` out 32: saturating count of cycles with `stall_if`=1.

## Operation
- Shadow stages E, M and W each hold {rd, rwrite, load}. E additionally holds {rn, rn_used, rm, rm_used}.
- Shadow stages advance exactly as the datapath does:
  - A stalled stage holds its contents.
  - A flushed stage or bubble clears `rwrite`, `load` and both `*_used` bits.
- Register 15 never causes a hazard or a forward. A match on rd=15 is treated as no match.
- The FSM has two states, RUN and MEMWAIT. The wait counter `wcnt` is 8 bits.
- **RUN**
  - If M is valid with `mem_req`=1 and `mem_ready`=0: assert all four stalls. W receives a bubble. Go to MEMWAIT with `wcnt`=1.
  - Else if `ex_branch_taken`=1: assert `flush_id` and `flush_ex` for one cycle. No stalls.
  - Else if there is a load-use hazard (E.load and E.rwrite and E.rd equals a used ID source): assert `stall_if` and `stall_id`, plus `flush_ex`. A bubble enters E. Lasts one cycle only.
  - Priority order: memory wait, then branch, then load-use.
- **MEMWAIT**
  - Assert all four stalls. `ex_branch_taken` and load-use conditions are ignored.
  - If `mem_ready`=1: deassert the stalls in this same cycle and return to RUN.
  - Else if `wcnt`=`MEM_TIMEOUT`: pulse `mem_err`, deassert the stalls, treat the M instruction as retired with `rwrite` cleared in W, and return to RUN.
  - Otherwise increment `wcnt`.
- A branch frozen in E during MEMWAIT takes effect on the release cycle, because `ex_branch_taken` is still asserted then.
- **Forwarding**, evaluated separately for each operand:
  - Select 10 if M.rwrite, not M.load, and M.rd equals the E source.
  - Else select 01 if W.rwrite and W.rd equals the E source.
  - Else select 00. An unused source always gets 00.
- `stall_count` increments on every cycle with `stall_if`=1 and holds at 0xFFFFFFFF.

## Timing
- Stall, flush and fwd outputs are combinational from the current inputs and the registered shadow/FSM state. They act in the same cycle.
- Shadow stages, the FSM state, `wcnt`, `mem_err` and `stall_count` are registered.
- `mem_err` is registered: it is high during the cycle after the timeout-detect edge.
- Reset values: FSM state RUN, all shadow bits 0, `wcnt`=0, `stall_count`=0, `mem_err`=0. All combinational outputs therefore evaluate to 0 / 00 while reset is held.
- Reset asserted mid-MEMWAIT: the block returns to RUN immediately. No `mem_err` pulse.
- Load-use stall latency is exactly 1 cycle. Branch flush is exactly 1 cycle.
- A memory wait stalls for N cycles when `mem_ready` rises on the Nth cycle after the request; the maximum is `MEM_TIMEOUT`.

## Test plan
- Load-use: LDR r3 in E and ADD using r3 in ID.
  - Expect one cycle with `stall_if`=`stall_id`=`flush_ex`=1.
  - On the next cycle the ADD is in E with `fwd_a`=01 (load in W).
- ALU back-to-back: ADD r2 followed by SUB using r2 then ORR using r2.
  - Expect no stalls.
  - SUB gets `fwd`=10; ORR gets `fwd`=01.
  - r15 as the destination gives 00.
- Branch taken while a load-use hazard is also present.
  - Expect `flush_id`=`flush_ex`=1 with all stalls 0.
  - `stall_count` unchanged.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles.
  - Expect all stalls high for those 3 cycles, release in the cycle `mem_ready` rises, `stall_count`=3.
  - With `ex_branch_taken` held throughout, the flush appears only on the release cycle.
- Timeout with `MEM_TIMEOUT`=4 and `mem_ready` held at 0.
  - Expect 4 stall cycles, then a `mem_err` pulse.
  - The aborted load forwards nothing.
- Reset asserted during MEMWAIT.
  - Expect all outputs 0 asynchronously, `stall_count`=0, and normal operation afterward.
